// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types, including memory arbiter state encodings
package lc3b_types;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        ARB_REQ_I,
        ARB_REQ_D
    } arb_req_t;

endpackage

// File: rtl/arbiter_control.sv
// rtl/arbiter_control.sv - arbiter FSM: round-robin grant in IDLE, hold until pmem_resp
import lc3b_types::*;

module arbiter_control (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    input  logic d_req,
    input  logic pmem_resp,
    output logic load_i,
    output logic load_d,
    output logic serve_i,
    output logic serve_d
);

    arb_state_t state, state_next;
    arb_req_t   last_grant, last_grant_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_REQ_I;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        load_i          = 1'b0;
        load_d          = 1'b0;
        case (state)
            ARB_IDLE: begin
                // On a tie the cache that did not win last time is granted.
                if (d_req && (!i_req || last_grant == ARB_REQ_I)) begin
                    state_next      = ARB_SERVE_D;
                    last_grant_next = ARB_REQ_D;
                    load_d          = 1'b1;
                end else if (i_req) begin
                    state_next      = ARB_SERVE_I;
                    last_grant_next = ARB_REQ_I;
                    load_i          = 1'b1;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (pmem_resp) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign serve_i = (state == ARB_SERVE_I);
    assign serve_d = (state == ARB_SERVE_D);

endmodule

// File: rtl/register.sv
// rtl/register.sv - load-enabled register with asynchronous active-low clear
module register #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pmem line port between the I-cache and D-cache
module mem_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    logic              load_i;
    logic              load_d;
    logic              serve_i;
    logic              serve_d;
    logic              op_write;
    logic [ADDR_W-1:0] address_next;

    arbiter_control control (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_read),
        .d_req     (d_read | d_write),
        .pmem_resp (pmem_resp),
        .load_i    (load_i),
        .load_d    (load_d),
        .serve_i   (serve_i),
        .serve_d   (serve_d)
    );

    assign address_next = load_d ? d_address : i_address;

    register #(.width(ADDR_W)) address_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_i | load_d),
        .d       (address_next),
        .q       (pmem_address)
    );

    register #(.width(LINE_W)) wdata_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_d),
        .d       (d_wdata),
        .q       (pmem_wdata)
    );

    // A simultaneous read+write from the D-cache is latched as a write.
    register #(.width(1)) op_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_d),
        .d       (d_write),
        .q       (op_write)
    );

    assign pmem_read  = serve_i | (serve_d & ~op_write);
    assign pmem_write = serve_d & op_write;

    assign i_resp  = serve_i & pmem_resp;
    assign d_resp  = serve_d & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] LINE_AA = {16{8'hAA}};
    localparam logic [127:0] LINE_W1 = {2{64'h0123456789ABCDEF}};
    localparam logic [127:0] LINE_55 = {16{8'h55}};

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(128), .ADDR_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_address", pmem_address, 16'h0);
        check("rst_wdata", pmem_wdata, 128'h0);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
    endtask

    // Entered just after the grant edge; serves one transaction then checks the IDLE cycle.
    task automatic complete(input string tag, input logic [15:0] ea, input logic er, input logic ew,
                            input logic [127:0] ewd, input logic ed, input logic [127:0] rdata);
        @(negedge clk);
        check({tag, "_addr"}, pmem_address, ea);
        check({tag, "_strobes"}, {pmem_read, pmem_write}, {er, ew});
        if (ew) check({tag, "_wdata"}, pmem_wdata, ewd);
        check({tag, "_noresp"}, {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1 pmem_resp = 1'b1;
        pmem_rdata = rdata;
        @(negedge clk);
        check({tag, "_resp"}, {i_resp, d_resp}, {~ed, ed});
        check({tag, "_rdata"}, ed ? d_rdata : i_rdata, rdata);
        check({tag, "_addr_hold"}, pmem_address, ea);
        @(posedge clk);
        #1 pmem_resp = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        check({tag, "_idle_strobes"}, {pmem_read, pmem_write}, 2'b00);
        check({tag, "_idle_resp"}, {i_resp, d_resp}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Single I-cache read.
        do_reset();
        @(posedge clk);
        #1 i_read = 1'b1;
        i_address = 16'h0040;
        @(posedge clk);
        #1;
        complete("iread", 16'h0040, 1'b1, 1'b0, '0, 1'b0, LINE_AA);
        i_read = 1'b0;

        // Both caches held: D wins the first tie, then strict alternation.
        do_reset();
        @(posedge clk);
        #1 i_read = 1'b1;
        i_address = 16'h0100;
        d_read = 1'b1;
        d_address = 16'h0200;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (k % 2 == 0)
                complete($sformatf("alt%0d_d", k), 16'h0200, 1'b1, 1'b0, '0, 1'b1, LINE_55);
            else
                complete($sformatf("alt%0d_i", k), 16'h0100, 1'b1, 1'b0, '0, 1'b0, LINE_AA);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("alt_after_idle", {pmem_read, pmem_write}, 2'b00);

        // Write-back with requester inputs changing mid-service.
        do_reset();
        @(posedge clk);
        #1 d_write = 1'b1;
        d_address = 16'h1230;
        d_wdata = LINE_W1;
        @(posedge clk);
        #1 d_address = 16'hFFF0;
        d_wdata = LINE_55;
        complete("dwrite", 16'h1230, 1'b0, 1'b1, LINE_W1, 1'b1, LINE_AA);
        d_write = 1'b0;

        // Read and write both high resolves to a write.
        do_reset();
        @(posedge clk);
        #1 d_read = 1'b1;
        d_write = 1'b1;
        d_address = 16'h0440;
        d_wdata = LINE_55;
        @(posedge clk);
        #1;
        complete("drw", 16'h0440, 1'b0, 1'b1, LINE_55, 1'b1, LINE_AA);
        d_read = 1'b0;
        d_write = 1'b0;

        // Reset mid-transaction, then a stray pmem_resp.
        do_reset();
        @(posedge clk);
        #1 d_write = 1'b1;
        d_address = 16'h3000;
        d_wdata = LINE_W1;
        @(posedge clk);
        #1 check("rmid_write_on", pmem_write, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("rmid_async_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rmid_async_address", pmem_address, 16'h0);
        check("rmid_async_resp", {i_resp, d_resp}, 2'b00);
        d_write = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 pmem_resp = 1'b1;
        pmem_rdata = LINE_AA;
        #3;
        check("rmid_late_resp", {i_resp, d_resp}, 2'b00);
        check("rmid_late_strobes", {pmem_read, pmem_write}, 2'b00);
        @(posedge clk);
        #1 pmem_resp = 1'b0;
        @(negedge clk);
        check("rmid_stays_idle", {pmem_read, pmem_write}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
